// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: walks the playfield RAM one cell at a time and paints
// every pixel of the board into the VGA framebuffer adapter, one pixel per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold, write low
// S_FETCH | cell_addr presented to the synchronous playfield RAM
// S_WAIT  | RAM data captured; first pixel of the cell prepared
// S_DRAW  | one pixel written per cycle, px fastest, then py
module tetris_board_renderer #(
  parameter int         COLS       = 10,
  parameter int         ROWS       = 20,
  parameter int         CELL       = 16,
  parameter int         X0         = 240,
  parameter int         Y0         = 80,
  parameter logic [8:0] GRID_COLOR = 9'o111
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  output logic [7:0] cell_addr,
  input  logic [2:0] cell_data,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [8:0] color,
  output logic       write,
  output logic       busy,
  output logic       done
);

  localparam int            PW        = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [PW-1:0] PMAX      = PW'(CELL - 1);
  localparam logic [7:0]    COL_LAST  = 8'(COLS - 1);
  localparam logic [7:0]    ADDR_LAST = 8'(COLS * ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW} state_t;

  state_t        state_q;
  logic [7:0]    row_q, col_q;
  logic [PW-1:0] px_q, py_q;
  logic [2:0]    cell_q;
  logic [7:0]    cell_addr_q;
  logic [9:0]    x_q;
  logic [8:0]    y_q;
  logic [8:0]    color_q;
  logic          write_q, busy_q, done_q;

  logic [PW-1:0] px_d, py_d;
  logic          last_px, last_pix, last_col, last_cell;

  function automatic logic [8:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 9'o000;
      3'd1:    return 9'o077;
      3'd2:    return 9'o770;
      3'd3:    return 9'o507;
      3'd4:    return 9'o070;
      3'd5:    return 9'o700;
      3'd6:    return 9'o007;
      default: return 9'o740;
    endcase
  endfunction

  // Empty cells show only the top/left grid lines so adjacent cells share one line.
  function automatic logic [8:0] pixel_color(input logic [2:0] idx,
                                             input logic [PW-1:0] px,
                                             input logic [PW-1:0] py);
    logic [8:0] pal;
    pal = palette(idx);
    if (idx == 3'd0)
      return (px == '0 || py == '0) ? GRID_COLOR : 9'o000;
    if (px == '0 || py == '0 || px == PMAX || py == PMAX)
      return {1'b0, pal[8:7], 1'b0, pal[5:4], 1'b0, pal[2:1]};
    return pal;
  endfunction

  function automatic logic [9:0] pixel_x(input logic [7:0] col, input logic [PW-1:0] px);
    return 10'(X0) + 10'(col) * 10'(CELL) + 10'(px);
  endfunction

  function automatic logic [8:0] pixel_y(input logic [7:0] row, input logic [PW-1:0] py);
    return 9'(Y0) + 9'(row) * 9'(CELL) + 9'(py);
  endfunction

  // Scan position decode and next pixel within the current cell.
  always_comb begin
    last_px   = (px_q == PMAX);
    last_pix  = last_px && (py_q == PMAX);
    last_col  = (col_q == COL_LAST);
    last_cell = (cell_addr_q == ADDR_LAST);
    px_d      = last_px ? '0 : px_q + 1'b1;
    py_d      = last_px ? py_q + 1'b1 : py_q;
  end

  // Sequencer with registered pixel, address and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      cell_q      <= '0;
      cell_addr_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= '0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FETCH;
            row_q       <= '0;
            col_q       <= '0;
            cell_addr_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          // Pixel (0,0) is built straight from the RAM output so DRAW writes from its first cycle.
          cell_q  <= cell_data;
          px_q    <= '0;
          py_q    <= '0;
          x_q     <= pixel_x(col_q, '0);
          y_q     <= pixel_y(row_q, '0);
          color_q <= pixel_color(cell_data, '0, '0);
          write_q <= 1'b1;
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (last_pix) begin
            write_q <= 1'b0;
            if (last_cell) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_FETCH;
              cell_addr_q <= cell_addr_q + 8'd1;
              if (last_col) begin
                col_q <= '0;
                row_q <= row_q + 8'd1;
              end else begin
                col_q <= col_q + 8'd1;
              end
            end
          end else begin
            px_q    <= px_d;
            py_q    <= py_d;
            x_q     <= pixel_x(col_q, px_d);
            y_q     <= pixel_y(row_q, py_d);
            color_q <= pixel_color(cell_q, px_d, py_d);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cell_addr = cell_addr_q;
  assign x         = x_q;
  assign y         = y_q;
  assign color     = color_q;
  assign write     = write_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
